// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state/opcode types and sequence lengths for the I2C register sequencer
package i2c_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_RELEASE, S_NEXT, S_DONE, S_ABORT
    } state_e;
    typedef enum logic [1:0] {OP_START, OP_WR, OP_RD, OP_STOP} op_e;
    typedef enum logic [2:0] {SEL_NONE, SEL_DEVW, SEL_DEVR, SEL_REG, SEL_DATA} sel_e;
    localparam int unsigned WR_LEN = 5;
    localparam int unsigned RD_LEN = 8;
endpackage

// File: rtl/i2c_reg_seq_if.sv
// i2c_reg_seq_if: register request/response bus and byte-master command lines
interface i2c_reg_seq_if;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       m_tr_en, m_start_gen, m_stop_gen, m_tr_gen, m_rec_gen;
    logic [7:0] m_tx_data;
    logic [9:0] m_comp;
    logic       m_tx_rx_req, m_tx_rx_req_ack;
    logic [7:0] m_rx_data;
    modport slave (
        input  req_valid, req_rw, req_dev, req_reg, req_wdata, m_tx_rx_req_ack, m_rx_data,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, m_tr_en, m_start_gen, m_stop_gen,
               m_tr_gen, m_rec_gen, m_tx_data, m_comp, m_tx_rx_req
    );
    modport master (
        output req_valid, req_rw, req_dev, req_reg, req_wdata, m_tx_rx_req_ack, m_rx_data,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, m_tr_en, m_start_gen, m_stop_gen,
               m_tr_gen, m_rec_gen, m_tx_data, m_comp, m_tx_rx_req
    );
endinterface

// File: rtl/i2c_seq_rom.sv
// i2c_seq_rom: maps step index and direction to the step opcode and the byte to send
module i2c_seq_rom import i2c_pkg::*; (
    input  logic [2:0] step,
    input  logic       rw,
    output op_e        op,
    output sel_e       sel
);
    always_comb begin
        op  = OP_STOP;
        sel = SEL_NONE;
        case ({rw, step})
            4'b0_000, 4'b1_000, 4'b1_100: op = OP_START;
            4'b0_001, 4'b1_001: begin op = OP_WR; sel = SEL_DEVW; end
            4'b0_010, 4'b1_010: begin op = OP_WR; sel = SEL_REG;  end
            4'b0_011:           begin op = OP_WR; sel = SEL_DATA; end
            4'b1_101:           begin op = OP_WR; sel = SEL_DEVR; end
            4'b1_110:           op = OP_RD;
            default:            op = OP_STOP;
        endcase
    end
endmodule

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: sequences one I2C register write or read as byte-level master commands
module i2c_reg_seq import i2c_pkg::*; #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned COMP    = 100
) (
    input logic          clk,
    input logic          resetn,
    i2c_reg_seq_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    state_e        state, state_nx;
    logic [2:0]    step;
    logic [CW-1:0] cnt;
    logic          rw_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q, wdata_q, rdata_q, tx_byte;
    op_e           op;
    sel_e          sel;
    logic          accept, active, ack, tc, last;

    i2c_seq_rom u_rom (.step(step), .rw(rw_q), .op(op), .sel(sel));

    assign ack    = bus.m_tx_rx_req_ack;
    assign accept = bus.req_valid && bus.req_ready;
    assign active = state inside {S_ISSUE, S_WAIT_ACK, S_RELEASE};
    assign tc     = cnt == CW'(TIMEOUT - 1);
    assign last   = step == (rw_q ? 3'(RD_LEN - 1) : 3'(WR_LEN - 1));

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= S_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = bus.req_valid ? S_ISSUE : S_IDLE;
            S_ISSUE:    state_nx = S_WAIT_ACK;
            S_WAIT_ACK: state_nx = ack ? S_RELEASE : tc ? S_ABORT : S_WAIT_ACK;
            S_RELEASE:  state_nx = !ack ? S_NEXT : tc ? S_ABORT : S_RELEASE;
            S_NEXT:     state_nx = last ? S_DONE : S_ISSUE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // The wait counter wraps at TIMEOUT so a release phase that follows an ack on
    // the terminal cycle gets its own full window instead of aborting at once.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            step    <= '0;
            cnt     <= '0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                rw_q    <= bus.req_rw;
                dev_q   <= bus.req_dev;
                reg_q   <= bus.req_reg;
                wdata_q <= bus.req_wdata;
                step    <= '0;
            end else if (state == S_ABORT) step <= '0;
            else if (state == S_NEXT && !last) step <= step + 3'd1;
            if (state_nx == S_ISSUE) cnt <= '0;
            else if (state inside {S_WAIT_ACK, S_RELEASE}) cnt <= tc ? '0 : cnt + 1'b1;
            if (state == S_WAIT_ACK && ack && op == OP_RD) rdata_q <= bus.m_rx_data;
        end

    assign tx_byte = sel == SEL_DEVW ? {dev_q, 1'b0} :
                     sel == SEL_DEVR ? {dev_q, 1'b1} :
                     sel == SEL_REG  ? reg_q :
                     sel == SEL_DATA ? wdata_q : 8'h00;

    assign bus.req_ready   = state == S_IDLE;
    assign bus.rsp_valid   = state inside {S_DONE, S_ABORT};
    assign bus.rsp_err     = state == S_ABORT;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.m_tr_en     = state != S_ABORT;
    assign bus.m_tx_rx_req = state inside {S_ISSUE, S_WAIT_ACK};
    assign bus.m_start_gen = active && op == OP_START;
    assign bus.m_tr_gen    = active && op == OP_WR;
    assign bus.m_rec_gen   = active && op == OP_RD;
    assign bus.m_stop_gen  = active && op == OP_STOP;
    assign bus.m_tx_data   = active ? tx_byte : 8'h00;
    assign bus.m_comp      = 10'(COMP);
endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed transactions against a step-list model with a per-cycle compare process
module tb_i2c_reg_seq;
    localparam int TO = 64;
    typedef struct packed { logic [3:0] g; logic [7:0] b; } step_t;
    typedef struct packed { logic err; logic rd; logic [7:0] rdata; logic [6:0] dev; } rsp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    i2c_reg_seq_if bus();
    i2c_reg_seq #(.TIMEOUT(TO), .COMP(100)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0, errors = 0;
    int n_cmd = 0, req_hi = 0, trn_low = 0;
    int ack_delay = 20, hi = 0, lo = 3;
    bit ack_never = 1'b0, busy = 1'b0, prev_req = 1'b0, last_err = 1'b0;
    logic [7:0] rd_val = 8'h3C;
    logic [31:0] glog = '0;
    logic [3:0] cur_g = '0;
    logic [7:0] cur_b = '0;
    step_t exp_steps[$];
    rsp_t exp_rsp[$];
    logic [7:0] tx_log[$];
    logic [6:0] done_log[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Step codes: 1=START 2=WRITE 3=READ 4=STOP
    function automatic void push_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        exp_steps.push_back('{4'd1, 8'h00});
        exp_steps.push_back('{4'd2, {dev, 1'b0}});
        exp_steps.push_back('{4'd2, rg});
        if (!rw) begin
            exp_steps.push_back('{4'd2, wd});
            exp_steps.push_back('{4'd4, 8'h00});
        end else begin
            exp_steps.push_back('{4'd4, 8'h00});
            exp_steps.push_back('{4'd1, 8'h00});
            exp_steps.push_back('{4'd2, {dev, 1'b1}});
            exp_steps.push_back('{4'd3, 8'h00});
            exp_steps.push_back('{4'd4, 8'h00});
        end
        exp_rsp.push_back('{ack_never, rw, rd_val, dev});
    endfunction

    // Master model: ack after ack_delay cycles of request, dropped 3 cycles after request falls
    initial begin
        bus.m_tx_rx_req_ack = 1'b0;
        bus.m_rx_data = 8'hEE;
    end
    always @(posedge clk) begin
        #1;
        if (!resetn || !bus.m_tr_en) begin
            hi = 0;
            lo = 3;
            bus.m_tx_rx_req_ack = 1'b0;
        end else if (bus.m_tx_rx_req) begin
            lo = 0;
            hi++;
            if (!ack_never && hi > ack_delay) bus.m_tx_rx_req_ack = 1'b1;
        end else begin
            hi = 0;
            lo++;
            if (lo >= 3) bus.m_tx_rx_req_ack = 1'b0;
        end
        bus.m_rx_data = bus.m_tx_rx_req_ack ? rd_val : 8'hEE;
    end

    always @(negedge clk) begin : mon
        step_t s;
        rsp_t r;
        logic [3:0] g;
        if (!resetn) begin
            exp_steps.delete();
            exp_rsp.delete();
            busy = 1'b0;
            prev_req = 1'b0;
        end else begin
            check("req_ready", bus.req_ready, !busy);
            check("m_comp", bus.m_comp, 100);
            g = bus.m_start_gen ? 4'd1 : bus.m_tr_gen ? 4'd2 : bus.m_rec_gen ? 4'd3 : bus.m_stop_gen ? 4'd4 : 4'd0;
            if (bus.m_tx_rx_req) begin
                req_hi++;
                check("gen_onehot", $countones({bus.m_start_gen, bus.m_tr_gen, bus.m_rec_gen, bus.m_stop_gen}), 1);
                if (!prev_req) begin
                    n_cmd++;
                    if (exp_steps.size() == 0) fail("unexpected_cmd");
                    else begin
                        s = exp_steps.pop_front();
                        check("gen", g, s.g);
                        if (s.g == 4'd2) check("tx_data", bus.m_tx_data, s.b);
                    end
                    glog = {glog[27:0], g};
                    if (g == 4'd2) tx_log.push_back(bus.m_tx_data);
                    cur_g = g;
                    cur_b = bus.m_tx_data;
                end else begin
                    check("gen_stable", g, cur_g);
                    check("tx_stable", bus.m_tx_data, cur_b);
                end
            end else if (prev_req && !bus.rsp_valid) begin
                check("gen_release", g, cur_g);
                check("tx_release", bus.m_tx_data, cur_b);
            end
            if (!bus.m_tr_en) trn_low++;
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) fail("unexpected_rsp");
                else begin
                    r = exp_rsp.pop_front();
                    check("rsp_err", bus.rsp_err, r.err);
                    check("tr_en_rsp", bus.m_tr_en, !r.err);
                    if (r.err) exp_steps.delete();
                    else begin
                        check("steps_left", exp_steps.size(), 0);
                        if (r.rd) check("rsp_rdata", bus.rsp_rdata, r.rdata);
                    end
                    done_log.push_back(r.dev);
                end
                last_err = bus.rsp_err;
                busy = 1'b0;
            end else check("tr_en", bus.m_tr_en, 1);
            if (bus.req_valid && bus.req_ready) begin
                push_txn(bus.req_rw, bus.req_dev, bus.req_reg, bus.req_wdata);
                busy = 1'b1;
            end
            prev_req = bus.m_tx_rx_req;
        end
    end

    task automatic send(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_rw = rw;
        bus.req_dev = dev;
        bus.req_reg = rg;
        bus.req_wdata = wd;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                bus.req_rw = !rw;
                bus.req_dev = 7'h7F;
                bus.req_reg = 8'hFF;
                bus.req_wdata = 8'h00;
                return;
            end
        end
        fail("accept_timeout");
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_rsp.size() == 0) return;
        end
        fail("done_timeout");
    endtask

    task automatic check_reset(input string t);
        check({t, "_req_ready"}, bus.req_ready, 1);
        check({t, "_rsp_valid"}, bus.rsp_valid, 0);
        check({t, "_rsp_err"}, bus.rsp_err, 0);
        check({t, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({t, "_m_req"}, bus.m_tx_rx_req, 0);
        check({t, "_gens"}, {bus.m_start_gen, bus.m_tr_gen, bus.m_rec_gen, bus.m_stop_gen}, 0);
        check({t, "_tx_data"}, bus.m_tx_data, 0);
        check({t, "_tr_en"}, bus.m_tr_en, 1);
    endtask

    initial begin
        int base, nd;
        bus.req_valid = 1'b0;
        bus.req_rw = 1'b0;
        bus.req_dev = '0;
        bus.req_reg = '0;
        bus.req_wdata = '0;
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1 resetn = 1'b1;

        glog = '0;
        tx_log.delete();
        send(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done(1000);
        check("wr_gen_order", glog, 32'h12224);
        check("wr_tx_count", tx_log.size(), 3);
        check("wr_tx0", tx_log[0], 8'hA0);
        check("wr_tx1", tx_log[1], 8'h10);
        check("wr_tx2", tx_log[2], 8'hA5);
        check("wr_err", last_err, 0);

        glog = '0;
        tx_log.delete();
        send(1'b1, 7'h50, 8'h22, 8'h00);
        wait_done(1000);
        check("rd_gen_order", glog, 32'h12241234);
        check("rd_tx0", tx_log[0], 8'hA0);
        check("rd_tx1", tx_log[1], 8'h22);
        check("rd_tx2", tx_log[2], 8'hA1);
        check("rd_rdata", bus.rsp_rdata, 8'h3C);

        // ISSUE cycle plus TIMEOUT wait cycles before the abort
        ack_never = 1'b1;
        glog = '0;
        req_hi = 0;
        trn_low = 0;
        send(1'b0, 7'h50, 8'h10, 8'h5A);
        wait_done(1000);
        check("to_req_cycles", req_hi, TO + 1);
        check("to_tr_en_low", trn_low, 1);
        check("to_gen_order", glog, 32'h1);
        check("to_err", last_err, 1);
        ack_never = 1'b0;

        ack_delay = TO;
        send(1'b0, 7'h21, 8'h33, 8'h44);
        wait_done(2000);
        check("tie_err", last_err, 0);
        check("tie_dev", done_log[done_log.size() - 1], 7'h21);

        ack_delay = 5;
        tx_log.delete();
        nd = done_log.size();
        send(1'b0, 7'h50, 8'h01, 8'h02);
        send(1'b1, 7'h51, 8'h03, 8'h00);
        wait_done(2000);
        check("b2b_count", done_log.size() - nd, 2);
        check("b2b_first", done_log[nd], 7'h50);
        check("b2b_second", done_log[nd + 1], 7'h51);
        check("b2b_tx2", tx_log[2], 8'h02);
        check("b2b_tx3", tx_log[3], 8'hA2);
        check("b2b_tx5", tx_log[5], 8'hA3);

        base = n_cmd;
        nd = done_log.size();
        send(1'b1, 7'h50, 8'h22, 8'h00);
        for (int i = 0; i < 500 && n_cmd < base + 4; i++) @(negedge clk);
        check("rst_step3_reached", n_cmd - base, 4);
        #2 resetn = 1'b0;
        @(posedge clk);
        #1;
        check_reset("mid");
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_rsp", done_log.size(), nd);

        glog = '0;
        send(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done(1000);
        check("post_rst_gen_order", glog, 32'h12224);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end
endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 Parameter TIMEOUT, default 4096, SHALL set the per-command ack-wait limit in clk cycles.
REQ-002 Parameter COMP, default 100, SHALL be the constant value driven on m_comp.
REQ-003 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  register transaction request.
REQ-006 req_ready  out  1  high only in IDLE.
REQ-007 req_rw  in  1  0 = write, 1 = read.
REQ-008 req_dev  in  7  I2C device address.
REQ-009 req_reg  in  8  register address.
REQ-010 req_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_err  out  1  timeout abort flag, valid with rsp_valid.
REQ-013 rsp_rdata  out  8  read data, valid with rsp_valid when req_rw=1.
REQ-014 m_tr_en, m_start_gen, m_stop_gen, m_tr_gen, m_rec_gen  out  1 each  master control lines.
REQ-015 m_tx_data  out  8  byte to the master.
REQ-016 m_comp  out  10  timing compare value to the master.
REQ-017 m_tx_rx_req  out  1  command request to the master.
REQ-018 m_tx_rx_req_ack  in  1  command acknowledge from the master.
REQ-019 m_rx_data  in  8  received byte from the master.

Function
REQ-020 On req_valid & req_ready, the block SHALL latch rw, dev, reg and wdata, and SHALL ignore these inputs until the next IDLE.
REQ-021 Write sequence SHALL be: START, WR {dev,0}, WR reg, WR wdata, STOP (5 steps).
REQ-022 Read sequence SHALL be: START, WR {dev,0}, WR reg, STOP, START, WR {dev,1}, RD, STOP (8 steps).
  - A separate STOP+START is used; no repeated start.
REQ-023 States SHALL be IDLE, ISSUE, WAIT_ACK, RELEASE, NEXT, DONE, ABORT.
REQ-024 Transition rules:
  - IDLE->ISSUE on accept.
  - ISSUE->WAIT_ACK after 1 cycle.
  - WAIT_ACK->RELEASE when ack=1.
  - RELEASE->NEXT when ack=0.
  - NEXT->ISSUE if steps remain, else ->DONE.
  - DONE->IDLE after 1 cycle.
  - ABORT->IDLE after 1 cycle.
REQ-025 In ISSUE and WAIT_ACK, the block SHALL drive m_tx_rx_req=1, exactly one gen line matching the step, and m_tx_data for the step; m_tx_rx_req SHALL be 0 in all other states.
REQ-026 Gen lines and m_tx_data SHALL stay stable from ISSUE through RELEASE.
REQ-027 On leaving WAIT_ACK from an RD step, the block SHALL capture m_rx_data into rsp_rdata.
REQ-028 m_tr_en SHALL be 1 in every state except ABORT.
REQ-029 Timeout counter:
  - Clears on entry to ISSUE.
  - Counts in WAIT_ACK and RELEASE.
  - Reaching TIMEOUT-1 SHALL force ABORT.
  - In ABORT, m_tr_en=0 for 1 cycle (resets the master); rsp_valid=1 and rsp_err=1 in the same cycle.
REQ-030 In DONE: rsp_valid=1, rsp_err=0.
REQ-031 The step counter SHALL be 3 bits and SHALL clear on accept and on ABORT.
REQ-032 Simultaneous ack=1 and timeout terminal count in WAIT_ACK: ack SHALL win.
REQ-033 req_valid during a busy transaction SHALL be held off via req_ready=0 and SHALL NOT be dropped by the requester.

Reset
REQ-034 Reset values:
  - State = IDLE.
  - req_ready = 1.
  - rsp_valid, rsp_err, rsp_rdata = 0.
  - m_tx_rx_req and all gen lines = 0.
  - m_tx_data = 0.
  - m_tr_en = 1.
  - Counters = 0.
REQ-035 Reset mid-transaction SHALL return to IDLE immediately with no rsp_valid pulse.

Structure
REQ-036 The shared package i2c_pkg SHALL hold the state enum, the step-opcode enum (OP_START, OP_WR, OP_RD, OP_STOP) and the write/read sequence lengths.
REQ-037 One sub-module, i2c_seq_rom (combinational step+rw -> opcode/byte select), SHALL be used.

Verification
REQ-038 Write dev=0x50, reg=0x10, wdata=0xA5, with an ack model (ack 20 cycles after req, drops 3 cycles after req falls) -> tx bytes 0xA0, 0x10, 0xA5; gen order S,T,T,T,P; rsp_valid=1, rsp_err=0.
REQ-039 Read dev=0x50, reg=0x22, model returns 0x3C -> tx bytes 0xA0, 0x22, 0xA1; gen order S,T,T,P,S,T,R,P; rsp_rdata=0x3C.
REQ-040 Ack never asserted, TIMEOUT=64 -> ABORT at cycle 64 of step 0; m_tr_en low for 1 cycle; rsp_err=1.
REQ-041 req_valid held high during a busy transaction -> second request accepted only after rsp_valid; both complete in order.
REQ-042 resetn low during step 3 of a read -> all outputs at reset values on the next edge; no rsp_valid.
REQ-043 Ack and timeout in the same cycle -> normal completion, rsp_err=0.
